nibble_serial_adder: RTL and testbench

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

---
 rtl/nibble_serial_adder.sv | 174 +++++++++++++++++
 tb/tb_nibble_serial_adder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder
// Adds two W-bit operands plus a carry-in one 4-bit nibble per clock,
// LSB nibble first, with a valid/ready handshake on each side.
//
// Parameters:
//   NIBBLES   : nibbles per operand (1..8), operand width W = 4*NIBBLES
//
// Ports:
//   clk       : sole clock, rising edge
//   rst       : synchronous active-high reset
//   in_valid  : a, b, c presented
//   in_ready  : block can accept operands (IDLE)
//   a, b      : W-bit operands
//   c         : carry-in
//   out_valid : sum/carry valid (DONE)
//   out_ready : consumer accepts the result
//   sum       : a+b+c modulo 2^W
//   carry     : carry-out of bit W-1
//   ovf       : signed overflow of the result (only when
//               NIBBLE_SERIAL_ADDER_OVF_EN is defined)
//
// Optional feature macro: NIBBLE_SERIAL_ADDER_OVF_EN
// -----------------------------------------------------------------------------
module nibble_serial_adder #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 c,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 carry
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    ,
    output logic                 ovf
`endif
);

    localparam int unsigned W     = 4 * NIBBLES;
    localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [W-1:0]     a_reg;
    logic [W-1:0]     b_reg;
    logic [W-1:0]     a_next;
    logic [W-1:0]     b_next;
    logic [W-1:0]     sum_next;
    logic             carry_next;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_next;
    logic             in_ready_next;
    logic             out_valid_next;

    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [4:0]       nib_sum;

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    logic [3:0]       low3_sum;
    logic             ovf_next;
`endif

    // One nibble of the ripple: carry register doubles as the running carry.
    always_comb begin
        a_nib   = a_reg[4*idx +: 4];
        b_nib   = b_reg[4*idx +: 4];
        nib_sum = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry};
    end

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    // Carry into the nibble's top bit; on the last nibble that is bit W-1.
    always_comb begin
        low3_sum = {1'b0, a_nib[2:0]} + {1'b0, b_nib[2:0]} + {3'b000, carry};
    end
`endif

    // Next-state and datapath next values.
    always_comb begin
        state_next = state;
        a_next     = a_reg;
        b_next     = b_reg;
        sum_next   = sum;
        carry_next = carry;
        idx_next   = idx;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        ovf_next   = ovf;
`endif

        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    a_next     = a;
                    b_next     = b;
                    carry_next = c;
                    idx_next   = '0;
                    state_next = ADD;
                end
            end

            ADD: begin
                sum_next[4*idx +: 4] = nib_sum[3:0];
                carry_next           = nib_sum[4];
                if (idx == LAST_IDX) begin
                    idx_next   = '0;
                    state_next = DONE;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
                    ovf_next   = low3_sum[3] ^ nib_sum[4];
`endif
                end else begin
                    idx_next = idx + IDX_W'(1);
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // Handshake flags are registered alongside the state they decode.
        in_ready_next  = (state_next == IDLE);
        out_valid_next = (state_next == DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum       <= '0;
            carry     <= 1'b0;
            idx       <= '0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            in_ready  <= in_ready_next;
            out_valid <= out_valid_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            sum       <= sum_next;
            carry     <= carry_next;
            idx       <= idx_next;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
            ovf       <= ovf_next;
`endif
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_nibble_serial_adder
// Scoreboard bench for nibble_serial_adder (NIBBLES=4). The driver pushes the
// reference result a+b+c for every accepted operation; a monitor pops and
// compares whenever a result handshake occurs. The driver also checks reset
// values, latency, backpressure holding and mid-operation reset.
// -----------------------------------------------------------------------------
module tb_nibble_serial_adder;

    localparam int unsigned NIBBLES = 4;
    localparam int unsigned W       = 4 * NIBBLES;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         carry;
    logic         ovf_w;

    int           n_tests = 0;
    int           n_fail  = 0;
    logic [W+1:0] exp_q[$];
    logic [W+1:0] mon_exp;

    always #5 clk = ~clk;

    nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry     (carry)
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        ,
        .ovf       (ovf_w)
`endif
    );

`ifndef NIBBLE_SERIAL_ADDER_OVF_EN
    assign ovf_w = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain wide addition; packed as {ovf, carry, sum}.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic ci);
        logic [W:0] full;
        logic       v;
        full = {1'b0, x} + {1'b0, y} + (W+1)'(ci);
        v    = 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        v = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
`endif
        return {v, full[W], full[W-1:0]};
    endfunction

    // Monitor: a result handshake completes at the next rising edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'(1), 32'(0));
            end else begin
                mon_exp = exp_q.pop_front();
                check("result", 32'({ovf_w, carry, sum}), 32'(mon_exp));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full operation: present, scramble inputs while busy, stall the
    // consumer for `stall` DONE cycles, then release.
    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                         input int stall);
        int           w;
        int           lat;
        logic [W+1:0] e;
        w = 0;
        while (!in_ready && w < 20) begin
            step();
            w++;
        end
        check("ready_before_op", 32'(in_ready), 32'(1));

        e         = model(x, y, ci);
        a         = x;
        b         = y;
        c         = ci;
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        exp_q.push_back(e);
        step();

        // Accepted; operand changes from here on must not matter.
        in_valid = 1'b0;
        a        = '1;
        b        = W'($urandom);
        c        = ~ci;
        lat      = 1;
        while (!out_valid && lat < 20) begin
            in_valid = 1'($urandom);
            a        = W'($urandom);
            b        = W'($urandom);
            step();
            lat++;
        end
        check("latency", 32'(lat), 32'(NIBBLES + 1));

        for (int k = 0; k < stall; k++) begin
            check("hold_out_valid", 32'(out_valid), 32'(1));
            check("hold_in_ready", 32'(in_ready), 32'(0));
            check("hold_result", 32'({carry, sum}), 32'(e[W:0]));
            in_valid = 1'($urandom);
            step();
        end
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
        check("idle_out_valid", 32'(out_valid), 32'(0));
        check("idle_in_ready", 32'(in_ready), 32'(1));
        out_ready = 1'($urandom);
    endtask

    initial begin
        int w;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        c         = 1'b0;
        repeat (3) step();
        check("rst_in_ready", 32'(in_ready), 32'(1));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_sum", 32'(sum), 32'(0));
        check("rst_carry", 32'(carry), 32'(0));
        check("rst_ovf", 32'(ovf_w), 32'(0));
        rst = 1'b0;
        step();

        // Directed cases.
        do_op(16'h0004, 16'h000B, 1'b0, 0);
        do_op(16'hFFFF, 16'h0001, 1'b0, 0);
        do_op(16'h00FF, 16'h0000, 1'b1, 0);
        do_op(16'h1234, 16'h4321, 1'b0, 3);
        do_op(16'h7FFF, 16'h0001, 1'b0, 0);
        do_op(16'h8000, 16'h8000, 1'b0, 1);
        do_op(16'h0F0F, 16'h0101, 1'b0, 0);
        do_op(16'hFFFF, 16'hFFFF, 1'b1, 2);

        // Reset during the second ADD cycle discards the operation.
        a         = 16'h1234;
        b         = 16'h1111;
        c         = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_in_ready", 32'(in_ready), 32'(1));
        check("abort_out_valid", 32'(out_valid), 32'(0));
        check("abort_sum", 32'(sum), 32'(0));
        check("abort_carry", 32'(carry), 32'(0));
        do_op(16'h0001, 16'h0001, 1'b0, 0);

        // Randomized operations.
        for (int i = 0; i < 40; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        w = 0;
        while (exp_q.size() != 0 && w < 20) begin
            step();
            w++;
        end
        check("scoreboard_drained", 32'(exp_q.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
